// File: rtl/ecc_apb_pkg.sv
// Shared definitions for the ECC APB register bank: register offsets,
// FSM state types, ECC operation codes and STATUS bit positions.
package ecc_apb_pkg;

    // Register byte offsets (exact match on the full APB address)
    localparam int unsigned ADDR_CTRL      = 32'h00;
    localparam int unsigned ADDR_DATA_IN   = 32'h04;
    localparam int unsigned ADDR_CW_WIDTH  = 32'h08;
    localparam int unsigned ADDR_NOISE     = 32'h0C;
    localparam int unsigned ADDR_STATUS    = 32'h10;
    localparam int unsigned ADDR_DATA_OUT  = 32'h14;

    // STATUS register bit positions
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_DONE      = 1;
    localparam int unsigned STAT_NERR_LO   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } core_state_t;

    typedef enum logic [1:0] {
        ENCODE = 2'd0,
        DECODE = 2'd1,
        FULL   = 2'd2
    } ecc_op_t;

    // The reserved operation code 3 behaves as a full channel run
    function automatic ecc_op_t map_op(input logic [1:0] code);
        return (code == 2'd3) ? FULL : ecc_op_t'(code);
    endfunction

endpackage

// File: rtl/ecc_apb_fsm.sv
// APB3 phase tracker: identifies the SETUP and ACCESS phases of the current
// cycle, producing the write-commit and read-sample strobes and the address
// latched during SETUP.
module ecc_apb_fsm
    import ecc_apb_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic                       wr_commit,
    output logic                       rd_sample,
    output logic                       in_access,
    output logic [AMBA_ADDR_WIDTH-1:0] addr_q
);

    apb_state_t state_q;
    apb_state_t state_d;

    // Phase register: holds the bus phase seen in the previous cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; state_d is also the phase of the current cycle,
    // so the strobes below fire in the cycle the bus is in that phase
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (psel && !penable) state_d = SETUP;
            end
            SETUP: begin
                if (psel && penable)       state_d = ACCESS;
                else if (psel && !penable) state_d = SETUP;
            end
            ACCESS: begin
                if (psel && !penable) state_d = SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_access = (state_d == ACCESS);
    assign wr_commit = in_access && pwrite;
    assign rd_sample = (state_d == SETUP) && !pwrite;

    // Address captured in SETUP and used for the ACCESS-phase decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else if (state_d == SETUP) begin
            addr_q <= paddr;
        end
    end

endmodule

// File: rtl/ecc_apb_regbank.sv
// APB3 zero-wait-state register bank for the ECC core: configuration
// registers, one-cycle start pulse, result capture and sticky done flag.
// Optional build macro ECC_APB_PSLVERR_EN adds a pslverr output.
module ecc_apb_regbank
    import ecc_apb_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic                       pwrite,
    input  logic                       psel,
    input  logic                       penable,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic [1:0]                 sel_o,
    output logic [AMBA_WORD-1:0]       data_in_o,
    output logic [AMBA_WORD-1:0]       noise_o,
    output logic [1:0]                 codeword_width_o,
    output logic                       start_o,
    input  logic                       core_done_i,
    input  logic [DATA_WIDTH-1:0]      core_data_i,
    input  logic [1:0]                 core_num_err_i,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [1:0]                 num_of_errors,
`ifdef ECC_APB_PSLVERR_EN
    output logic                       pslverr,
`endif
    output logic                       operation_done
);

    localparam logic [AMBA_ADDR_WIDTH-1:0] A_CTRL     = AMBA_ADDR_WIDTH'(ADDR_CTRL);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA_IN  = AMBA_ADDR_WIDTH'(ADDR_DATA_IN);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_CW_WIDTH = AMBA_ADDR_WIDTH'(ADDR_CW_WIDTH);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_NOISE    = AMBA_ADDR_WIDTH'(ADDR_NOISE);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_STATUS   = AMBA_ADDR_WIDTH'(ADDR_STATUS);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA_OUT = AMBA_ADDR_WIDTH'(ADDR_DATA_OUT);

    logic                       wr_commit;
    logic                       rd_sample;
    logic                       in_access;
    logic [AMBA_ADDR_WIDTH-1:0] addr_q;

    logic [1:0]           ctrl_q;
    logic [1:0]           cw_width_q;
    logic [AMBA_WORD-1:0] data_in_q;
    logic [AMBA_WORD-1:0] noise_q;
    logic                 done_q;
    logic [AMBA_WORD-1:0] rd_mux;

    core_state_t core_state_q;
    core_state_t core_state_d;

    logic busy;
    logic wr_cfg_ok;
    logic ctrl_launch;
    logic capture;
    logic status_rd_done;

    ecc_apb_fsm #(
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
    ) u_apb_fsm (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .wr_commit (wr_commit),
        .rd_sample (rd_sample),
        .in_access (in_access),
        .addr_q    (addr_q)
    );

    assign busy           = (core_state_q == C_RUN);
    assign wr_cfg_ok      = wr_commit && !busy;
    assign ctrl_launch    = wr_cfg_ok && (addr_q == A_CTRL);
    assign capture        = busy && core_done_i;
    assign status_rd_done = in_access && !pwrite && (addr_q == A_STATUS);

    assign sel_o            = map_op(ctrl_q);
    assign data_in_o        = data_in_q;
    assign noise_o          = noise_q;
    assign codeword_width_o = cw_width_q;

    // Core sequencing state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_state_q <= C_IDLE;
        end else begin
            core_state_q <= core_state_d;
        end
    end

    // Core sequencing: run from an accepted CTRL write until the core reports done
    always_comb begin
        core_state_d = core_state_q;
        case (core_state_q)
            C_IDLE: if (ctrl_launch) core_state_d = C_RUN;
            C_RUN:  if (core_done_i) core_state_d = C_IDLE;
            default: core_state_d = C_IDLE;
        endcase
    end

    // Configuration registers; writes are dropped while the core is running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            data_in_q  <= '0;
            cw_width_q <= '0;
            noise_q    <= '0;
        end else if (wr_cfg_ok) begin
            case (addr_q)
                A_CTRL:     ctrl_q     <= pwdata[1:0];
                A_DATA_IN:  data_in_q  <= pwdata;
                A_CW_WIDTH: cw_width_q <= pwdata[1:0];
                A_NOISE:    noise_q    <= pwdata;
                default: ;
            endcase
        end
    end

    // Start pulse, result capture, completion pulse and sticky done (set wins over clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_o        <= 1'b0;
            operation_done <= 1'b0;
            data_out       <= '0;
            num_of_errors  <= '0;
            done_q         <= 1'b0;
        end else begin
            start_o        <= ctrl_launch;
            operation_done <= capture;
            if (capture) begin
                data_out      <= core_data_i;
                num_of_errors <= core_num_err_i;
            end
            if (capture) begin
                done_q <= 1'b1;
            end else if (status_rd_done) begin
                done_q <= 1'b0;
            end
        end
    end

    // Read multiplexer on the live SETUP-phase address
    always_comb begin
        rd_mux = '0;
        case (paddr)
            A_CTRL:     rd_mux[1:0] = ctrl_q;
            A_DATA_IN:  rd_mux      = data_in_q;
            A_CW_WIDTH: rd_mux[1:0] = cw_width_q;
            A_NOISE:    rd_mux      = noise_q;
            A_STATUS: begin
                rd_mux[STAT_BUSY]         = busy;
                rd_mux[STAT_DONE]         = done_q;
                rd_mux[STAT_NERR_LO +: 2] = num_of_errors;
            end
            A_DATA_OUT: rd_mux      = AMBA_WORD'(data_out);
            default:    rd_mux      = '0;
        endcase
    end

    // Read data is registered at the end of SETUP and held through ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prdata <= '0;
        end else if (rd_sample) begin
            prdata <= rd_mux;
        end
    end

`ifdef ECC_APB_PSLVERR_EN
    logic addr_mapped;
    logic addr_ro;
    logic addr_cfg;

    // Error classification of the ACCESS-phase address
    always_comb begin
        addr_mapped = 1'b0;
        addr_ro     = 1'b0;
        addr_cfg    = 1'b0;
        case (addr_q)
            A_CTRL, A_DATA_IN, A_CW_WIDTH, A_NOISE: begin
                addr_mapped = 1'b1;
                addr_cfg    = 1'b1;
            end
            A_STATUS, A_DATA_OUT: begin
                addr_mapped = 1'b1;
                addr_ro     = 1'b1;
            end
            default: ;
        endcase
    end

    assign pslverr = in_access &&
                     (!addr_mapped || (pwrite && addr_ro) || (pwrite && busy && addr_cfg));
`endif

endmodule

// File: tb/tb_ecc_apb_regbank.sv
// Randomised scoreboard bench for ecc_apb_regbank. Stimulus tasks push the
// expected response of every APB access, start pulse and completion pulse
// into queues; a negedge monitor pops and compares when the DUT presents them.
module tb_ecc_apb_regbank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic [1:0]  sel_o;
    logic [31:0] data_in_o;
    logic [31:0] noise_o;
    logic [1:0]  codeword_width_o;
    logic        start_o;
    logic        core_done_i = 1'b0;
    logic [31:0] core_data_i = '0;
    logic [1:0]  core_num_err_i = '0;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done;
`ifdef ECC_APB_PSLVERR_EN
    logic        pslverr;
`endif

    ecc_apb_regbank #(
        .AMBA_ADDR_WIDTH (20),
        .AMBA_WORD       (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .paddr            (paddr),
        .pwrite           (pwrite),
        .psel             (psel),
        .penable          (penable),
        .pwdata           (pwdata),
        .prdata           (prdata),
        .sel_o            (sel_o),
        .data_in_o        (data_in_o),
        .noise_o          (noise_o),
        .codeword_width_o (codeword_width_o),
        .start_o          (start_o),
        .core_done_i      (core_done_i),
        .core_data_i      (core_data_i),
        .core_num_err_i   (core_num_err_i),
        .data_out         (data_out),
        .num_of_errors    (num_of_errors),
`ifdef ECC_APB_PSLVERR_EN
        .pslverr          (pslverr),
`endif
        .operation_done   (operation_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        bit          err;
    } acc_t;

    typedef struct {
        int          at;
        logic [31:0] d;
        logic [1:0]  e;
    } done_t;

    acc_t  acc_q[$];
    int    start_q[$];
    done_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the register bank
    logic [1:0]  m_ctrl, m_cw, m_nerr;
    logic [31:0] m_din, m_noise, m_dout;
    bit          m_busy, m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_cw = '0; m_nerr = '0;
        m_din = '0; m_noise = '0; m_dout = '0;
        m_busy = 0; m_done = 0;
    endtask

    function automatic bit m_mapped(input logic [19:0] a);
        return (a <= 20'h14) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] m_read(input logic [19:0] a);
        case (a)
            20'h00:  return {30'b0, m_ctrl};
            20'h04:  return m_din;
            20'h08:  return {30'b0, m_cw};
            20'h0C:  return m_noise;
            20'h10:  return {28'b0, m_nerr, m_done, m_busy};
            20'h14:  return m_dout;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_done(input logic [31:0] cd, input logic [1:0] ce, input bit was_busy);
        if (was_busy) begin
            done_q.push_back('{cyc + 1, cd, ce});
            m_busy = 0;
            m_done = 1;
            m_dout = cd;
            m_nerr = ce;
        end
    endtask

    task automatic apb_write(input logic [19:0] a, input logic [31:0] d,
                             input bit with_done = 0, input logic [31:0] cd = '0,
                             input logic [1:0] ce = '0);
        bit cfg, err, was_busy;
        @(posedge clk); #1;
        core_done_i = 0;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        was_busy = m_busy;
        cfg = m_mapped(a) && (a <= 20'h0C);
        err = !m_mapped(a) || (a >= 20'h10) || (cfg && was_busy);
        acc_q.push_back('{0, 32'h0, err});
        if (with_done) begin
            core_done_i = 1; core_data_i = cd; core_num_err_i = ce;
        end
        if (cfg && !was_busy) begin
            case (a)
                20'h00: begin
                    m_ctrl = d[1:0];
                    m_busy = 1;
                    start_q.push_back(cyc + 1);
                end
                20'h04: m_din   = d;
                20'h08: m_cw    = d[1:0];
                20'h0C: m_noise = d;
                default: ;
            endcase
        end
        if (with_done) model_done(cd, ce, was_busy);
    endtask

    task automatic apb_read(input logic [19:0] a);
        logic [31:0] exp;
        @(posedge clk); #1;
        core_done_i = 0;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        exp = m_read(a);
        @(posedge clk); #1;
        penable = 1;
        acc_q.push_back('{1, exp, !m_mapped(a)});
        if (a == 20'h10) m_done = 0;
    endtask

    task automatic apb_idle();
        @(posedge clk); #1;
        core_done_i = 0;
        psel = 0; penable = 0;
    endtask

    task automatic core_finish(input logic [31:0] cd, input logic [1:0] ce);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        core_done_i = 1; core_data_i = cd; core_num_err_i = ce;
        model_done(cd, ce, m_busy);
    endtask

    task automatic check_ports();
        chk("sel_o", {30'b0, sel_o}, {30'b0, (m_ctrl == 2'd3) ? 2'd2 : m_ctrl});
        chk("data_in_o", data_in_o, m_din);
        chk("noise_o", noise_o, m_noise);
        chk("codeword_width_o", {30'b0, codeword_width_o}, {30'b0, m_cw});
    endtask

    // Monitor: pops expectations whenever the DUT presents an access or pulse
    always @(negedge clk) begin
        if (rst) begin
            if (psel && penable) begin
                if (acc_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL access_unexpected: got an ACCESS, required none (cycle %0d)", cyc);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    if (a.rd) chk("prdata", prdata, a.data);
`ifdef ECC_APB_PSLVERR_EN
                    chk("pslverr", {31'b0, pslverr}, {31'b0, a.err});
`endif
                end
            end
            if (start_o) begin
                if (start_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL start_unexpected: got start_o=1, required 0 (cycle %0d)", cyc);
                end else begin
                    chk("start_cycle", cyc, start_q.pop_front());
                end
            end
            if (operation_done) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL op_done_unexpected: got operation_done=1, required 0 (cycle %0d)", cyc);
                end else begin
                    done_t dn;
                    dn = done_q.pop_front();
                    chk("op_done_cycle", cyc, dn.at);
                    chk("data_out", data_out, dn.d);
                    chk("num_of_errors", {30'b0, num_of_errors}, {30'b0, dn.e});
                end
            end
        end
    end

    logic [19:0] addr_tab [8] = '{20'h00, 20'h04, 20'h08, 20'h0C,
                                  20'h10, 20'h14, 20'h20, 20'hF0004};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1;

        // Reset state
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_start_o", {31'b0, start_o}, 32'h0);
        chk("rst_operation_done", {31'b0, operation_done}, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        check_ports();

        // Configuration write and readback, back-to-back
        apb_write(20'h04, 32'hA5A5_0F0F);
        apb_write(20'h08, 32'h0000_0001);
        apb_write(20'h0C, 32'h0000_0010);
        apb_read(20'h04);
        apb_read(20'h08);
        apb_read(20'h0C);
        apb_read(20'h10);
        apb_idle();
        check_ports();

        // Launch, complete, sticky done cleared by STATUS read
        apb_write(20'h00, 32'h2);
        apb_idle();
        apb_read(20'h10);
        core_finish(32'h0000_1234, 2'd1);
        apb_read(20'h10);
        apb_read(20'h10);
        apb_read(20'h14);
        apb_idle();
        check_ports();

        // Writes while busy are ignored
        apb_write(20'h00, 32'h1);
        apb_idle();
        apb_write(20'h04, 32'hFFFF_FFFF);
        apb_write(20'h00, 32'h0);
        apb_read(20'h04);
        apb_idle();
        check_ports();

        // CTRL write coinciding with core completion
        apb_write(20'h00, 32'h3, 1, 32'h0000_BEEF, 2'd2);
        apb_idle();
        apb_read(20'h10);
        apb_idle();
        check_ports();

        // Unmapped read, then back-to-back reads
        apb_read(20'h20);
        apb_read(20'h04);
        apb_read(20'h08);
        apb_idle();

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0, 1: apb_write(addr_tab[$urandom_range(0, 7)],
                                ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3));
                2:    apb_read(addr_tab[$urandom_range(0, 7)]);
                3:    core_finish($urandom, 2'($urandom_range(0, 3)));
                default: begin
                    apb_idle();
                    check_ports();
                end
            endcase
        end
        apb_idle();
        apb_idle();

        // Reset in the middle of a run
        apb_write(20'h08, 32'h2);
        apb_write(20'h00, 32'h1);
        apb_idle();
        apb_idle();
        apb_read(20'h14);
        apb_idle();
        rst = 0;
        #1;
        model_reset();
        chk("midrst_prdata", prdata, 32'h0);
        chk("midrst_start_o", {31'b0, start_o}, 32'h0);
        chk("midrst_operation_done", {31'b0, operation_done}, 32'h0);
        chk("midrst_data_out", data_out, 32'h0);
        chk("midrst_num_of_errors", {30'b0, num_of_errors}, 32'h0);
        check_ports();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        core_finish(32'h5555_AAAA, 2'd3);
        apb_idle();
        apb_read(20'h10);
        apb_idle();

        repeat (5) apb_idle();
        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("start_q_drained", start_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ecc_apb_regbank.md
# ecc_apb_regbank

APB3 responder (zero-wait-state slave) that terminates the bus driven by the stimulus side of the ECC encoder/decoder environment. It holds the SEL, DATA_IN, CODEWORD_WIDTH and NOISE registers and issues a one-cycle start to the ECC core. It captures the core's result and exposes `data_out`, `num_of_errors` and `operation_done`. The block sits between the APB fabric and the ECC core datapath.

## Interface
- `AMBA_ADDR_WIDTH`, 20: APB address width
- `AMBA_WORD`, 32: APB data width
- `DATA_WIDTH`, 32: core result width
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: asynchronous, active-low reset
- `paddr` in AMBA_ADDR_WIDTH: APB address
- `pwrite`, `psel`, `penable` in 1 each: APB control
- `pwdata` in AMBA_WORD: APB write data
- `prdata` out AMBA_WORD: APB read data, registered
- `sel_o` out 2: operation (0 encode, 1 decode, 2 full channel, 3 reserved → treated as 2)
- `data_in_o`, `noise_o` out AMBA_WORD: core operand and noise mask
- `codeword_width_o` out 2: 0 = 8, 1 = 16, 2/3 = 32 bit codeword
- `start_o` out 1: one-cycle start pulse to core
- `core_done_i` in 1: core completion strobe
- `core_data_i` in DATA_WIDTH, `core_num_err_i` in 2: core result
- `data_out` out DATA_WIDTH, `num_of_errors` out 2: captured result
- `operation_done` out 1: one-cycle completion pulse

## Operation
- Register map (byte offsets, exact match on full `paddr`):
  - 0x00 CTRL[1:0], R/W; a write launches an operation
  - 0x04 DATA_IN, R/W
  - 0x08 CODEWORD_WIDTH[1:0], R/W
  - 0x0C NOISE, R/W
  - 0x10 STATUS, RO: bit0 busy, bit1 done (sticky), bits[3:2] num_of_errors
  - 0x14 DATA_OUT, RO
- Unmapped offsets: read 0; writes ignored.
- APB FSM states:
  - IDLE → SETUP on `psel & !penable`
  - SETUP → ACCESS (`penable` high)
  - ACCESS → SETUP if `psel` stays high, else IDLE
- Writes commit at the end of ACCESS. Read data is sampled at the end of SETUP so `prdata` is stable throughout ACCESS.
- Core FSM states:
  - C_IDLE → C_RUN on a CTRL write in C_IDLE
  - C_RUN → C_IDLE on `core_done_i`
- While busy (C_RUN), writes to 0x00–0x0C are ignored: no register change, no start.
- Completing a STATUS read clears done. If done sets in the same cycle, the set wins.
- `core_done_i` in C_IDLE is ignored; nothing is captured.
- Upper bits of CTRL and CODEWORD_WIDTH read back as 0.

## Timing
- Reset: every register, `prdata`, `start_o`, `operation_done`, `data_out`, `num_of_errors`, busy and done are 0; both FSMs go to IDLE. Reset mid-operation abandons the run with no pulse afterwards.
- CTRL write with ACCESS in cycle T: `start_o` is high in cycle T+1 only, and busy is 1 from T+1.
- Config registers written in cycle T are visible on the `*_o` ports from T+1. They are stable while busy.
- `core_done_i` high in cycle D:
  - `data_out` and `num_of_errors` are updated in D+1.
  - `operation_done` is high in D+1 only.
  - busy is 0 and done is 1 from D+1.
- A CTRL write in the same cycle as `core_done_i` is ignored, because busy is still 1 in that cycle.
- Back-to-back transfers: no idle cycle is required between a completed ACCESS and the next SETUP.

## Configuration
- `ECC_APB_PSLVERR_EN`: when defined, adds output `pslverr` (1 bit, reset 0).
  - `pslverr` is high during ACCESS for an unmapped offset, a write to a RO offset, or a write while busy.
  - Register behaviour is unchanged.
- When undefined, the port does not exist and these cases are silently ignored.

## Structure
- Package `ecc_apb_pkg` holds:
  - address offset localparams
  - `apb_state_t` {IDLE, SETUP, ACCESS}
  - `core_state_t` {C_IDLE, C_RUN}
  - `ecc_op_t` {ENCODE, DECODE, FULL}
  - STATUS bit positions
- Sub-module `ecc_apb_fsm`: APB phase tracking, producing `wr_commit`, `rd_sample` and the latched address. The top level holds the registers and the core FSM.

## Test plan
- Reset asserted mid-run: all outputs 0 immediately, no `start_o` or `operation_done` after release, STATUS reads 0x0.
- Write 0x04=0xA5A5_0F0F, 0x08=1, 0x0C=0x0000_0010, then read each back → values match; CODEWORD_WIDTH reads 0x1.
- Write CTRL=2 → `start_o` high exactly one cycle, STATUS = 0x1. Drive `core_done_i` with data 0x0000_1234 and errors 1 → `operation_done` single pulse. STATUS reads 0x6, then 0x4 on re-read. DATA_OUT reads 0x1234.
- While busy, write 0x04=0xFFFF_FFFF and CTRL=0 → DATA_IN unchanged, no second `start_o`. With the macro defined, `pslverr`=1 on both writes.
- CTRL write coinciding with `core_done_i` → single `operation_done`, no new start, busy=0.
- Read 0x20 → `prdata`=0. Back-to-back reads 0x04, 0x08 with no IDLE → correct data in each ACCESS.
